// File: rtl/mem_arbiter.sv
// Two-port (CPU / IP) arbiter onto a single-cycle data memory: grant -> mem_en next cycle -> ack after that.
// Fixed CPU priority by default; define DMEM_ARB_RR_EN for a 1-bit round-robin pointer.
module mem_arbiter #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   input  logic          ip_req,
   input  logic          ip_we,
   input  logic [AW-1:0] ip_addr,
   input  logic [DW-1:0] ip_wdata,
   output logic [DW-1:0] ip_rdata,
   output logic          ip_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          owner
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t        state_q;
   logic          owner_q;
   logic          mem_en_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic          cpu_ack_q;
   logic          ip_ack_q;
   logic [DW-1:0] cpu_rdata_q;
   logic [DW-1:0] ip_rdata_q;

   logic          idle_win;
   logic          grant_vld;
   logic          grant_sel;

`ifdef DMEM_ARB_RR_EN
   logic          rr_q;

   // rr_q names the requester that wins a tie: the one not granted last.
   always_comb idle_win = (cpu_req && ip_req) ? rr_q : ip_req;
`else
   always_comb idle_win = ~cpu_req;
`endif

   // In RESP only the other requester may be chained; the current winner is masked.
   always_comb begin
      grant_vld = 1'b0;
      grant_sel = 1'b0;
      case (state_q)
         IDLE: begin
            grant_vld = cpu_req | ip_req;
            grant_sel = idle_win;
         end
         RESP: begin
            grant_vld = owner_q ? cpu_req : ip_req;
            grant_sel = ~owner_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         ip_ack_q    <= 1'b0;
         cpu_rdata_q <= '0;
         ip_rdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
         rr_q        <= 1'b0;
`endif
      end else begin
         mem_en_q  <= 1'b0;
         mem_we_q  <= 1'b0;
         cpu_ack_q <= 1'b0;
         ip_ack_q  <= 1'b0;

         if (grant_vld) begin
            owner_q     <= grant_sel;
            mem_en_q    <= 1'b1;
            mem_we_q    <= grant_sel ? ip_we    : cpu_we;
            mem_addr_q  <= grant_sel ? ip_addr  : cpu_addr;
            mem_wdata_q <= grant_sel ? ip_wdata : cpu_wdata;
`ifdef DMEM_ARB_RR_EN
            rr_q        <= ~grant_sel;
`endif
         end

         if (state_q == RESP) begin
            if (owner_q) ip_rdata_q  <= mem_rdata;
            else         cpu_rdata_q <= mem_rdata;
         end

         case (state_q)
            IDLE:  if (grant_vld) state_q <= ISSUE;
            ISSUE: begin
               state_q   <= RESP;
               cpu_ack_q <= ~owner_q;
               ip_ack_q  <= owner_q;
            end
            RESP:    state_q <= grant_vld ? ISSUE : IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign ip_ack    = ip_ack_q;
   assign owner     = owner_q;
   // Memory data arrives in the ack cycle itself; the _q copy holds it afterwards.
   assign cpu_rdata = cpu_ack_q ? mem_rdata : cpu_rdata_q;
   assign ip_rdata  = ip_ack_q  ? mem_rdata : ip_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory plus an ack scoreboard.
module tb_mem_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic          ip_req = 1'b0, ip_we = 1'b0;
   logic [AW-1:0] ip_addr = '0;
   logic [DW-1:0] ip_wdata = '0;
   logic [DW-1:0] ip_rdata;
   logic          ip_ack;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          owner;

   typedef struct packed {
      logic          port;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   exp_t          e;
   logic [DW-1:0] mem [0:(1<<AW)-1];
   int            n_checks = 0;
   int            n_fail = 0;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .ip_req(ip_req), .ip_we(ip_we), .ip_addr(ip_addr), .ip_wdata(ip_wdata),
      .ip_rdata(ip_rdata), .ip_ack(ip_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   always #5 clk = ~clk;

   // Read-first synchronous memory: data one cycle after mem_en.
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= mem[mem_addr];
         if (mem_we) mem[mem_addr] = mem_wdata;
      end
   end

   task automatic push_exp(input logic port, input logic [DW-1:0] data);
      exp_t x;
      x.port = port;
      x.data = data;
      sb.push_back(x);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({cpu_ack, ip_ack, mem_en, mem_we, owner} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {cpu_ack, ip_ack, mem_en, mem_we, owner});
      end
      n_checks++;
      if (mem_addr !== '0 || mem_wdata !== '0) begin
         n_fail++; $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0/0", mem_addr, mem_wdata);
      end
      n_checks++;
      if (cpu_rdata !== '0 || ip_rdata !== '0) begin
         n_fail++; $display("FAIL reset_rdata: got cpu %h ip %h expected 0/0", cpu_rdata, ip_rdata);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_en !== 1'b0 || cpu_ack !== 1'b0 || ip_ack !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle: got en %b acks %b%b expected 0 00", mem_en, cpu_ack, ip_ack);
      end
   endtask

   task automatic test_single_read();
      mem[5] = 32'h0000_00AA;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
      push_exp(1'b0, 32'h0000_00AA);
      @(negedge clk);
      n_checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd5 || cpu_ack !== 1'b0) begin
         n_fail++; $display("FAIL read_issue: got en %b we %b addr %0d ack %b expected 1 0 5 0", mem_en, mem_we, mem_addr, cpu_ack);
      end
      @(negedge clk);
      n_checks++;
      e = sb.pop_front();
      if ({cpu_ack, ip_ack, cpu_rdata} !== {~e.port, e.port, e.data}) begin
         n_fail++; $display("FAIL read_ack: got acks %b%b rdata %h expected %b%b %h", cpu_ack, ip_ack, cpu_rdata, ~e.port, e.port, e.data);
      end
      cpu_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_en !== 1'b0 || cpu_ack !== 1'b0 || cpu_rdata !== 32'h0000_00AA) begin
         n_fail++; $display("FAIL read_after: got en %b ack %b rdata %h expected 0 0 000000aa", mem_en, cpu_ack, cpu_rdata);
      end
   endtask

   task automatic test_write_read();
      mem[3] = 32'h1234_5678;
      ip_req = 1'b1; ip_we = 1'b1; ip_addr = 10'd3; ip_wdata = 32'hDEAD_BEEF;
      push_exp(1'b1, 32'h1234_5678);
      @(negedge clk);
      n_checks++;
      if (owner !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL wr_issue: got owner %b en %b we %b wdata %h expected 1 1 1 deadbeef", owner, mem_en, mem_we, mem_wdata);
      end
      @(negedge clk);
      n_checks++;
      e = sb.pop_front();
      if ({cpu_ack, ip_ack, ip_rdata} !== {~e.port, e.port, e.data}) begin
         n_fail++; $display("FAIL wr_ack: got acks %b%b rdata %h expected %b%b %h", cpu_ack, ip_ack, ip_rdata, ~e.port, e.port, e.data);
      end
      ip_req = 1'b0; ip_we = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd3;
      push_exp(1'b0, 32'hDEAD_BEEF);
      @(negedge clk);
      n_checks++;
      if (owner !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 10'd3 || mem_we !== 1'b0) begin
         n_fail++; $display("FAIL rd_chain_issue: got owner %b en %b addr %0d we %b expected 0 1 3 0", owner, mem_en, mem_addr, mem_we);
      end
      n_checks++;
      if (mem[3] !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL wr_mem: got %h expected deadbeef", mem[3]);
      end
      @(negedge clk);
      n_checks++;
      e = sb.pop_front();
      if ({cpu_ack, ip_ack, cpu_rdata} !== {~e.port, e.port, e.data}) begin
         n_fail++; $display("FAIL rd_ack: got acks %b%b rdata %h expected %b%b %h", cpu_ack, ip_ack, cpu_rdata, ~e.port, e.port, e.data);
      end
      cpu_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_arbitration();
      pulse_reset();
      mem[10] = 32'hC0C0_0010;
      mem[20] = 32'h1F1F_0020;
      for (int i = 0; i < 8; i++) push_exp(i[0], i[0] ? 32'h1F1F_0020 : 32'hC0C0_0010);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd10;
      ip_req  = 1'b1; ip_we  = 1'b0; ip_addr  = 10'd20;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         n_checks++;
         if ((cpu_ack | ip_ack) !== (k % 2 == 0) || (cpu_ack & ip_ack) !== 1'b0) begin
            n_fail++; $display("FAIL arb_cadence: cycle %0d got acks %b%b expected one ack=%0d", k, cpu_ack, ip_ack, (k % 2 == 0));
         end
         if (cpu_ack || ip_ack) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL arb_sb: cycle %0d got ack %b%b expected none", k, cpu_ack, ip_ack);
            end else begin
               e = sb.pop_front();
               if ({cpu_ack, ip_ack, (ip_ack ? ip_rdata : cpu_rdata)} !== {~e.port, e.port, e.data}) begin
                  n_fail++; $display("FAIL arb_grant: cycle %0d got acks %b%b rdata %h expected %b%b %h", k, cpu_ack, ip_ack, (ip_ack ? ip_rdata : cpu_rdata), ~e.port, e.port, e.data);
               end
            end
         end
         if (k == 16) begin cpu_req = 1'b0; ip_req = 1'b0; end
      end
      @(negedge clk);
      n_checks++;
      if (mem_en !== 1'b0 || cpu_ack !== 1'b0 || ip_ack !== 1'b0 || sb.size() != 0) begin
         n_fail++; $display("FAIL arb_drain: got en %b acks %b%b pending %0d expected 0 00 0", mem_en, cpu_ack, ip_ack, sb.size());
      end
   endtask

   // After a lone CPU grant, a fresh tie from IDLE separates fixed priority from round-robin.
   task automatic test_priority();
      logic first;
`ifdef DMEM_ARB_RR_EN
      first = 1'b1;
`else
      first = 1'b0;
`endif
      pulse_reset();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd10;
      @(negedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      @(negedge clk);
      cpu_req = 1'b1; ip_req = 1'b1; ip_we = 1'b0; ip_addr = 10'd20;
      push_exp(first, first ? 32'h1F1F_0020 : 32'hC0C0_0010);
      push_exp(~first, first ? 32'hC0C0_0010 : 32'h1F1F_0020);
      @(negedge clk);
      n_checks++;
      if (owner !== first) begin
         n_fail++; $display("FAIL prio_owner: got %b expected %b", owner, first);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++;
         e = sb.pop_front();
         if ({cpu_ack, ip_ack, (ip_ack ? ip_rdata : cpu_rdata)} !== {~e.port, e.port, e.data}) begin
            n_fail++; $display("FAIL prio_ack%0d: got acks %b%b rdata %h expected %b%b %h", k, cpu_ack, ip_ack, (ip_ack ? ip_rdata : cpu_rdata), ~e.port, e.port, e.data);
         end
         if (e.port) ip_req = 1'b0; else cpu_req = 1'b0;
         if (k == 0) @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
      @(negedge clk);
      n_checks++;
      if (mem_en !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_issue: got en %b expected 1", mem_en);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({cpu_ack, ip_ack, mem_en, mem_we, owner} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0 || cpu_rdata !== '0 || ip_rdata !== '0) begin
         n_fail++; $display("FAIL rstmid_outputs: got ctrl %b addr %h wdata %h rdata %h/%h expected all 0", {cpu_ack, ip_ack, mem_en, mem_we, owner}, mem_addr, mem_wdata, cpu_rdata, ip_rdata);
      end
      @(negedge clk);
      n_checks++;
      if (cpu_ack !== 1'b0 || mem_en !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_noack: got ack %b en %b expected 0 0", cpu_ack, mem_en);
      end
      rst = 1'b0;
      push_exp(1'b0, 32'h0000_00AA);
      @(negedge clk);
      n_checks++;
      if (mem_en !== 1'b1 || mem_addr !== 10'd5 || cpu_ack !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_reissue: got en %b addr %0d ack %b expected 1 5 0", mem_en, mem_addr, cpu_ack);
      end
      @(negedge clk);
      n_checks++;
      e = sb.pop_front();
      if ({cpu_ack, ip_ack, cpu_rdata} !== {~e.port, e.port, e.data}) begin
         n_fail++; $display("FAIL rstmid_ack: got acks %b%b rdata %h expected %b%b %h", cpu_ack, ip_ack, cpu_rdata, ~e.port, e.port, e.data);
      end
      cpu_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int acks;
      acks = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
      push_exp(1'b0, 32'h0000_00AA);
      push_exp(1'b0, 32'hC0C0_0010);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (cpu_ack || ip_ack) begin
            acks++;
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL b2b_dup: cycle %0d got ack %b%b expected none", k, cpu_ack, ip_ack);
            end else begin
               e = sb.pop_front();
               if ({cpu_ack, ip_ack, cpu_rdata} !== {~e.port, e.port, e.data}) begin
                  n_fail++; $display("FAIL b2b_ack: cycle %0d got acks %b%b rdata %h expected %b%b %h", k, cpu_ack, ip_ack, cpu_rdata, ~e.port, e.port, e.data);
               end
            end
         end
         if (k == 3) begin
            n_checks++;
            if (mem_en !== 1'b0 || cpu_ack !== 1'b0) begin
               n_fail++; $display("FAIL b2b_idle_gap: got en %b ack %b expected 0 0", mem_en, cpu_ack);
            end
         end
         if (k == 2) cpu_req = 1'b0;
         if (k == 3) begin cpu_req = 1'b1; cpu_addr = 10'd10; end
         if (k == 5) cpu_req = 1'b0;
      end
      n_checks++;
      if (acks != 2) begin
         n_fail++; $display("FAIL b2b_count: got %0d acks expected 2", acks);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_read();
      test_arbitration();
      test_priority();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
